// File: rtl/imem_loader.sv
// imem_loader: packs a big-endian byte stream into 32-bit words and writes them into InstMem, holding the CPU while loading
module imem_loader #(
  parameter int ADDR_W  = 32,
  parameter int WORDS   = 64,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] word_count
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;
  state_t state;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] word_idx;
  logic [TW-1:0]     tcnt;
  logic [23:0]       pack;
  assign byte_ready = state == RECV;
  assign busy       = state == RECV || state == WRITE;
  assign cpu_hold   = busy;
  assign done       = state == DONE;
  assign error      = state == ERR;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      byte_idx   <= '0;
      word_idx   <= '0;
      word_count <= '0;
      tcnt       <= '0;
      pack       <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: if (start) begin
          state      <= RECV;
          byte_idx   <= '0;
          word_idx   <= '0;
          word_count <= '0;
          tcnt       <= '0;
        end
        RECV: if (byte_valid) begin
          // earlier bytes shift up so byte 0 lands in the top lane
          pack     <= {pack[15:0], byte_data};
          byte_idx <= byte_idx + 2'd1;
          tcnt     <= '0;
          if (byte_idx == 2'd3) begin
            state    <= WRITE;
            mem_we   <= 1'b1;
            mem_addr <= word_idx;
            mem_din  <= {pack, byte_data};
          end
        end else begin
          tcnt  <= tcnt + 1'b1;
          state <= tcnt == TW'(TIMEOUT - 1) ? ERR : RECV;
        end
        WRITE: begin
          mem_we     <= 1'b0;
          word_idx   <= word_idx + 1'b1;
          word_count <= word_count + 1'b1;
          state      <= word_count + 1'b1 == ADDR_W'(WORDS) ? DONE : RECV;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized loads checked against a word-packing reference built from the sent byte list
module tb_imem_loader;
  localparam int WORDS = 4;
  localparam int TOUT  = 10;
  logic        clk = 0, rst = 1, start = 0, byte_valid = 0;
  logic [7:0]  byte_data = 0;
  logic        byte_ready, mem_we, cpu_hold, busy, done, error;
  logic [31:0] mem_addr, mem_din, word_count;
  int cmp = 0, bad = 0;
  int cyc = 0, we_cyc = -1, done_cyc = -1, rdy_we = 0;
  logic done_d = 0;
  logic [31:0] wa[$], wd[$];
  logic [7:0]  byte_q[$];

  imem_loader #(.ADDR_W(32), .WORDS(WORDS), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .word_count(word_count));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_din);
      we_cyc <= cyc;
      if (byte_ready) rdy_we <= rdy_we + 1;
    end
    if (done && !done_d) done_cyc <= cyc;
    done_d <= done;
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    byte_valid = 1;
    byte_data  = b;
    while (!byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      bad++;
      $display("FAIL send_timeout: byte_ready stayed %0b, required 1", byte_ready);
    end
    cmp++;
    @(negedge clk);
    byte_valid = 0;
  endtask

  task automatic check_idle_outs(input string nm);
    cmp++;
    if ({byte_ready, mem_we, cpu_hold, busy, done, error} !== 6'b0 || mem_addr !== 0 || mem_din !== 0 || word_count !== 0) begin
      bad++;
      $display("FAIL %s: rdy/we/hold/busy/done/err=%b addr=%h din=%h cnt=%0d, required all 0",
               nm, {byte_ready, mem_we, cpu_hold, busy, done, error}, mem_addr, mem_din, word_count);
    end
  endtask

  // mode 0: back-to-back, 1: valid toggles every cycle, 2: random gaps; noise pulses start while busy
  task automatic run_load(input int mode, input bit noise, input string nm);
    int n;
    logic [31:0] w;
    while (byte_q.size() < 4 * WORDS) byte_q.push_back(8'($urandom));
    wa.delete();
    wd.delete();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    cmp++;
    if (busy !== 1 || cpu_hold !== 1 || done !== 0 || error !== 0 || word_count !== 0) begin
      bad++;
      $display("FAIL %s_start: busy=%b hold=%b done=%b err=%b cnt=%0d, required 1 1 0 0 0",
               nm, busy, cpu_hold, done, error, word_count);
    end
    for (int i = 0; i < 4 * WORDS; i++) begin
      start = noise && i >= 2 && i < 4 * WORDS - 1;
      send(byte_q[i]);
      if (i == 4 * WORDS - 2) begin
        cmp++;
        if (cpu_hold !== 1 || done !== 0) begin
          bad++;
          $display("FAIL %s_hold: hold=%b done=%b mid-load, required 1 0", nm, cpu_hold, done);
        end
      end
      if (mode == 1) @(negedge clk);
      if (mode == 2) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    start = 0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmp++;
    if (done !== 1 || cpu_hold !== 0 || error !== 0 || busy !== 0 || word_count !== WORDS) begin
      bad++;
      $display("FAIL %s_end: done=%b hold=%b err=%b busy=%b cnt=%0d, required 1 0 0 0 %0d",
               nm, done, cpu_hold, error, busy, word_count, WORDS);
    end
    cmp++;
    if (wa.size() != WORDS) begin
      bad++;
      $display("FAIL %s_nwrites: %0d writes, required %0d", nm, wa.size(), WORDS);
    end
    for (int i = 0; i < WORDS && i < wa.size(); i++) begin
      w = {byte_q[4*i], byte_q[4*i+1], byte_q[4*i+2], byte_q[4*i+3]};
      cmp++;
      if (wa[i] !== i || wd[i] !== w) begin
        bad++;
        $display("FAIL %s_word%0d: addr=%0d din=%h, required addr=%0d din=%h", nm, i, wa[i], wd[i], i, w);
      end
    end
    cmp++;
    if (done_cyc !== we_cyc + 1) begin
      bad++;
      $display("FAIL %s_done_lat: done rose at cycle %0d, last write %0d, required one cycle later", nm, done_cyc, we_cyc);
    end
    byte_q.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_idle_outs("reset");
    rst = 0;
    @(negedge clk);
    check_idle_outs("post_reset");
  endtask

  task automatic test_ignore_valid(input string nm);
    logic d0, e0, b0;
    int nw;
    d0 = done; e0 = error; b0 = busy; nw = wa.size();
    byte_valid = 1;
    byte_data  = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmp++;
      if (byte_ready !== 0 || done !== d0 || error !== e0 || busy !== b0) begin
        bad++;
        $display("FAIL %s: ready=%b done=%b err=%b busy=%b, required 0 %b %b %b", nm, byte_ready, done, error, busy, d0, e0, b0);
      end
    end
    byte_valid = 0;
    cmp++;
    if (wa.size() != nw) begin
      bad++;
      $display("FAIL %s_write: %0d writes, required %0d", nm, wa.size(), nw);
    end
  endtask

  task automatic test_basic();
    byte_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h02, 8'h00, 8'h00};
    run_load(0, 0, "basic");
  endtask

  task automatic test_backpressure();
    byte_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    rdy_we = 0;
    run_load(1, 0, "bp");
    cmp++;
    if (rdy_we !== 0) begin
      bad++;
      $display("FAIL bp_ready_in_write: byte_ready high in %0d write cycles, required 0", rdy_we);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    wa.delete();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    send($urandom);
    send($urandom);
    while (!error && n < 30) begin
      @(negedge clk);
      n++;
    end
    cmp++;
    if (n !== TOUT) begin
      bad++;
      $display("FAIL timeout_lat: error after %0d idle cycles, required %0d", n, TOUT);
    end
    cmp++;
    if (error !== 1 || cpu_hold !== 0 || busy !== 0 || wa.size() != 0) begin
      bad++;
      $display("FAIL timeout_state: err=%b hold=%b busy=%b writes=%0d, required 1 0 0 0", error, cpu_hold, busy, wa.size());
    end
  endtask

  task automatic test_reset_mid();
    wa.delete();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 5; i++) send($urandom);
    #2 rst = 1;
    #1 check_idle_outs("rst_mid");
    cmp++;
    if (wa.size() != 1) begin
      bad++;
      $display("FAIL rst_mid_writes: %0d writes before reset, required 1", wa.size());
    end
    @(negedge clk);
    rst = 0;
    run_load(2, 0, "reload");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) run_load(2, 1, "b2b");
  endtask

  initial begin
    test_reset();
    test_ignore_valid("ignore_idle");
    test_basic();
    test_ignore_valid("ignore_done");
    test_backpressure();
    test_timeout();
    test_ignore_valid("ignore_err");
    test_reset_mid();
    test_back_to_back();
    run_load(0, 1, "noise");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
